// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// seq_alu : execute-stage ALU with valid/ready handshake, registered result,
//           radix-2 iterative multiply and restoring divide.
// Optional: define SEQ_ALU_SIGNED_MULDIV_EN for signed DIV/REM (1110/1111).
// Revision: 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB_reg,
    input  logic [WIDTH-1:0] srcB_ImmExt,
    input  logic             ALUSrc,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_ADD   = 4'b0000;
    localparam logic [3:0] c_OP_SUB   = 4'b0001;
    localparam logic [3:0] c_OP_AND   = 4'b0010;
    localparam logic [3:0] c_OP_OR    = 4'b0011;
    localparam logic [3:0] c_OP_XOR   = 4'b0100;
    localparam logic [3:0] c_OP_SLT   = 4'b0101;
    localparam logic [3:0] c_OP_SLL   = 4'b0110;
    localparam logic [3:0] c_OP_SRL   = 4'b0111;
    localparam logic [3:0] c_OP_SRA   = 4'b1000;
    localparam logic [3:0] c_OP_SLTU  = 4'b1001;
    localparam logic [3:0] c_OP_MUL   = 4'b1010;
    localparam logic [3:0] c_OP_MULHU = 4'b1011;
    localparam logic [3:0] c_OP_DIVU  = 4'b1100;
    localparam logic [3:0] c_OP_REMU  = 4'b1101;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] c_OP_DIV   = 4'b1110;
    localparam logic [3:0] c_OP_REM   = 4'b1111;
`endif

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 hi_q, hi_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 w_is_sdiv;
`endif

    logic [WIDTH-1:0]     w_opb;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_div_a;
    logic [WIDTH-1:0]     w_div_b;
    logic [WIDTH-1:0]     w_single;
    logic                 w_last;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH-1:0]     w_mul_res;
    logic [WIDTH:0]       w_div_sh;
    logic                 w_div_ge;
    logic [WIDTH:0]       w_div_rem;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_div_res;

    assign w_opb   = ALUSrc ? srcB_ImmExt : srcB_reg;
    assign w_shamt = w_opb[SHAMT_W-1:0];
    assign w_last  = (cnt_q == SHAMT_W'(WIDTH - 1));

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign ALUResult = result_q;
    assign zero_out  = zero_q;

    // Operation decode; signed divide feeds magnitudes into the unsigned datapath
    always_comb begin
        w_is_mul = (ALUControl == c_OP_MUL) || (ALUControl == c_OP_MULHU);
        w_is_div = (ALUControl == c_OP_DIVU) || (ALUControl == c_OP_REMU);
        w_div_a  = srcA;
        w_div_b  = w_opb;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        w_is_sdiv = (ALUControl == c_OP_DIV) || (ALUControl == c_OP_REM);
        if (w_is_sdiv) begin
            w_is_div = 1'b1;
            if (srcA[WIDTH-1])  w_div_a = -srcA;
            if (w_opb[WIDTH-1]) w_div_b = -w_opb;
        end
`endif
    end

    always_comb begin
        w_single = '0;
        case (ALUControl)
            c_OP_ADD:  w_single = srcA + w_opb;
            c_OP_SUB:  w_single = srcA - w_opb;
            c_OP_AND:  w_single = srcA & w_opb;
            c_OP_OR:   w_single = srcA | w_opb;
            c_OP_XOR:  w_single = srcA ^ w_opb;
            c_OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(w_opb))};
            c_OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (srcA < w_opb)};
            c_OP_SLL:  w_single = srcA << w_shamt;
            c_OP_SRL:  w_single = srcA >> w_shamt;
            c_OP_SRA:  w_single = $signed(srcA) >>> w_shamt;
            default:   w_single = '0;
        endcase
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};
        w_mul_res  = hi_q ? w_mul_next[2*WIDTH-1:WIDTH] : w_mul_next[WIDTH-1:0];

        w_div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        w_div_ge   = (w_div_sh >= {1'b0, opd_q});
        w_div_rem  = w_div_ge ? (w_div_sh - {1'b0, opd_q}) : w_div_sh;
        w_div_next = {w_div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], w_div_ge};

        w_quo = w_div_next[WIDTH-1:0];
        w_rem = w_div_next[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        if (negq_q) w_quo = -w_div_next[WIDTH-1:0];
        if (negr_q) w_rem = -w_div_next[2*WIDTH-1:WIDTH];
`endif
        w_div_res = hi_q ? w_rem : w_quo;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        negq_d   = negq_q;
        negr_d   = negr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    hi_d  = ALUControl[0];
                    if (w_is_mul) begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, w_opb};
                        opd_d   = srcA;
                    end else if (w_is_div) begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, w_div_a};
                        opd_d   = w_div_b;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
                        // Divide-by-zero keeps the all-ones quotient unsigned
                        negq_d  = w_is_sdiv && (srcA[WIDTH-1] ^ w_opb[WIDTH-1])
                                  && (w_opb != '0);
                        negr_d  = w_is_sdiv && srcA[WIDTH-1];
`endif
                    end else begin
                        state_d  = S_DONE;
                        result_d = w_single;
                        zero_d   = (w_single == '0);
                    end
                end
            end
            S_MUL: begin
                acc_d = w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d  = S_DONE;
                    result_d = w_mul_res;
                    zero_d   = (w_mul_res == '0);
                end
            end
            S_DIV: begin
                acc_d = w_div_next;
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d  = S_DONE;
                    result_d = w_div_res;
                    zero_d   = (w_div_res == '0);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            negq_q   <= negq_d;
            negr_q   <= negr_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// tb_seq_alu : directed self-checking bench for seq_alu (WIDTH = 32).
// Revision: 1.0
// ============================================================================
module tb_seq_alu;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4;
    localparam logic [3:0] SLT = 4'h5, SLL = 4'h6, SRL = 4'h7, SRA = 4'h8, SLTU = 4'h9;
    localparam logic [3:0] MUL = 4'hA, MULHU = 4'hB, DIVU = 4'hC, REMU = 4'hD;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA;
    logic [31:0] srcB_reg;
    logic [31:0] srcB_ImmExt;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        zero_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .srcA        (srcA),
        .srcB_reg    (srcB_reg),
        .srcB_ImmExt (srcB_ImmExt),
        .ALUSrc      (ALUSrc),
        .ALUControl  (ALUControl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .zero_out    (zero_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/busy"},      32'(busy),      32'd0);
        chk({tag, "/result"},    ALUResult,      32'd0);
        chk({tag, "/zero"},      32'(zero_out),  32'd1);
    endtask

    // exp_edges: clock edges after the accepting edge until out_valid is seen
    // (0 for single-cycle ops, 32 for multiply/divide)
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] breg, input logic [31:0] bimm, input logic src,
                          input int exp_edges, input logic [31:0] exp_res);
        int edges;
        int busy_cnt;
        int rdy_bad;
        @(negedge clk);
        in_valid = 1'b1; ALUControl = ctl; srcA = a;
        srcB_reg = breg; srcB_ImmExt = bimm; ALUSrc = src;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; srcA = $urandom; srcB_reg = $urandom;
        srcB_ImmExt = $urandom; ALUSrc = 1'($urandom_range(0, 1)); ALUControl = 4'($urandom);
        edges = 0; busy_cnt = 0; rdy_bad = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "/latency"},    32'(edges),    32'(exp_edges));
        chk({tag, "/busy_cyc"},   32'(busy_cnt), 32'(exp_edges));
        chk({tag, "/ready_low"},  32'(rdy_bad),  32'd0);
        chk({tag, "/result"},     ALUResult,     exp_res);
        chk({tag, "/zero"},       32'(zero_out), 32'(exp_res == 32'd0));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/drain_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ALUControl = 4'h0;
        srcA = '0; srcB_reg = '0; srcB_ImmExt = '0; ALUSrc = 1'b0;
        #12;
        chk_reset("reset");
        @(negedge clk); rst_n = 1'b1;

        run_op("add",  ADD,  32'd5, 32'd3, 32'hDEAD, 1'b0, 0, 32'h0000_0008); consume("add");
        run_op("slt_imm", SLT, 32'd5, 32'd0, 32'h0000_000F, 1'b1, 0, 32'h0000_0001); consume("slt_imm");
        run_op("sub_eq", SUB, 32'd5, 32'd5, 32'd0, 1'b0, 0, 32'h0000_0000); consume("sub_eq");
        run_op("sub_neg", SUB, 32'd3, 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFE); consume("sub_neg");
        run_op("and_imm", AND_, 32'h0400_AB05, 32'h0, 32'h2170_0F03, 1'b1, 0, 32'h0000_0B01);
        consume("and_imm");
        run_op("sra", SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 0, 32'hF800_0000); consume("sra");
        run_op("sltu", SLTU, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 32'h0000_0001); consume("sltu");
        run_op("slt_neg", SLT, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 32'h0000_0000); consume("slt_neg");
        run_op("sll_max", SLL, 32'd1, 32'h0000_003F, 32'd0, 1'b0, 0, 32'h8000_0000); consume("sll_max");
        run_op("srl", SRL, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 0, 32'h0800_0000); consume("srl");
        run_op("xor", XOR_, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 0, 32'hF0F0_F0F0); consume("xor");
        run_op("or", OR_, 32'h0000_00F0, 32'h0, 32'h0000_000F, 1'b1, 0, 32'h0000_00FF); consume("or");
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        run_op("div_s", 4'hE, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 32, 32'hFFFF_FFF2); consume("div_s");
        run_op("rem_s", 4'hF, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 32, 32'hFFFF_FFFE); consume("rem_s");
`else
        run_op("undef_e", 4'hE, 32'd100, 32'd7, 32'd0, 1'b0, 0, 32'h0000_0000); consume("undef_e");
        run_op("undef_f", 4'hF, 32'd100, 32'd7, 32'd0, 1'b0, 0, 32'h0000_0000); consume("undef_f");
`endif

        // multiply result held under backpressure
        run_op("mul", MUL, 32'd7, 32'd6, 32'd0, 1'b0, 32, 32'h0000_002A);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp/result", ALUResult,      32'h0000_002A);
            chk("bp/valid",  32'(out_valid), 32'd1);
            chk("bp/ready",  32'(in_ready),  32'd0);
        end
        consume("mul");

        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 32'hFFFF_FFFE);
        consume("mulhu");
        run_op("mul_lo", MUL, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0001);
        consume("mul_lo");
        run_op("divu_z", DIVU, 32'd100, 32'd0, 32'd0, 1'b0, 32, 32'hFFFF_FFFF); consume("divu_z");
        run_op("remu_z", REMU, 32'd100, 32'd0, 32'd0, 1'b0, 32, 32'd100); consume("remu_z");
        run_op("divu", DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 32, 32'd14); consume("divu");
        run_op("remu", REMU, 32'd100, 32'd7, 32'd0, 1'b0, 32, 32'd2); consume("remu");

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; ALUControl = MUL; srcA = 32'd9; srcB_reg = 32'd9; ALUSrc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midmul/busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midmul_rst");
        @(negedge clk); rst_n = 1'b1;

        run_op("add_post", ADD, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1, 0, 32'h8000_0000);
        consume("add_post");
        run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 32'h0000_0000);
        consume("add_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
